// File: rtl/note_pkg.sv
// Shared definitions for the note scheduler: note table, ROM word layout,
// music-box FSM states.
package note_pkg;

    localparam logic [3:0] REST_IDX = 4'd0;

    // ROM word layout: [15:12] note index, [11:9] octave, [8:0] duration ticks
    localparam int IDX_LSB = 12;
    localparam int IDX_W   = 4;
    localparam int OCT_LSB = 9;
    localparam int OCT_W   = 3;
    localparam int DUR_LSB = 0;
    localparam int DUR_W   = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_PLAY  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    // Indices 1..7 are do..si; everything else is a rest (fcw 0).
    function automatic logic [15:0] note_fcw(input logic [3:0] idx);
        case (idx)
            4'd1:    return 16'd176;
            4'd2:    return 16'd197;
            4'd3:    return 16'd221;
            4'd4:    return 16'd234;
            4'd5:    return 16'd263;
            4'd6:    return 16'd295;
            4'd7:    return 16'd331;
            default: return 16'd0;
        endcase
    endfunction

    function automatic logic [2:0] oct_fix(input logic [2:0] oct);
        return (oct == 3'd0) ? 3'd1 : oct;
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Prescaled tick down-counter; done_o marks the last cycle of a loaded
// duration of ticks_i * TICK_DIV cycles.
module tick_timer #(
    parameter int TICK_DIV = 50000,
    parameter int CNT_W    = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             run_i,
    input  logic [CNT_W-1:0] ticks_i,
    output logic             done_o
);
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;

    assign tick   = run_i && (pre_q == PRE_LAST);
    assign done_o = tick && (cnt_q <= CNT_W'(1));

    always_comb begin
        pre_d = pre_q;
        cnt_d = cnt_q;
        if (load_i) begin
            pre_d = '0;
            cnt_d = ticks_i;
        end else if (!run_i) begin
            pre_d = '0;
        end else if (tick) begin
            pre_d = '0;
            cnt_d = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/note_scheduler.sv
// DDS front end: live priority keyboard or music-box sequencer over a
// synchronous note ROM, selected by mode.
module note_scheduler
    import note_pkg::*;
#(
    parameter int NKEYS     = 7,
    parameter int TICK_DIV  = 50000,
    parameter int ADDR_W    = 5,
    parameter int GAP_TICKS = 20,
    parameter int LOOP      = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NKEYS-1:0]  keys,
    input  logic [2:0]        octave_live,
    input  logic              mode,
    input  logic              play,
    input  logic              stop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [15:0]       fcw,
    output logic [2:0]        octave,
    output logic              gate_n,
    output logic              busy,
    output logic [3:0]        note_idx,
    output logic [2:0]        state_dbg
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       fcw_q, fcw_d;
    logic [2:0]        oct_q, oct_d;
    logic              gate_n_q, gate_n_d;
    logic [3:0]        idx_q, idx_d;

    logic              tmr_load, tmr_run, tmr_done;
    logic [DUR_W-1:0]  tmr_ticks;
    logic              live_hit;
    logic [3:0]        live_idx;
    logic [3:0]        w_idx;
    logic [DUR_W-1:0]  w_dur;
    logic [15:0]       w_fcw;

    assign w_idx   = rom_data[IDX_LSB +: IDX_W];
    assign w_dur   = rom_data[DUR_LSB +: DUR_W];
    assign w_fcw   = note_fcw(w_idx);
    assign tmr_run = (state_q == ST_PLAY) || (state_q == ST_GAP);

    tick_timer #(.TICK_DIV(TICK_DIV), .CNT_W(DUR_W)) u_timer (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (tmr_load),
        .run_i   (tmr_run),
        .ticks_i (tmr_ticks),
        .done_o  (tmr_done)
    );

    // Scan downwards so the lowest pressed key is the one left standing.
    always_comb begin
        live_hit = 1'b0;
        live_idx = REST_IDX;
        for (int k = NKEYS - 1; k >= 0; k--) begin
            if (keys[k]) begin
                live_hit = 1'b1;
                live_idx = 4'(k + 1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        fcw_d     = fcw_q;
        oct_d     = oct_q;
        gate_n_d  = gate_n_q;
        idx_d     = idx_q;
        tmr_load  = 1'b0;
        tmr_ticks = '0;
        if (!mode && state_q != ST_IDLE) begin
            state_d  = ST_IDLE;
            gate_n_d = 1'b1;
            idx_d    = REST_IDX;
        end else if (!mode) begin
            oct_d = oct_fix(octave_live);
            if (live_hit && note_fcw(live_idx) != 16'd0) begin
                fcw_d    = note_fcw(live_idx);
                gate_n_d = 1'b0;
                idx_d    = live_idx;
            end else begin
                gate_n_d = 1'b1;
                idx_d    = REST_IDX;
            end
        end else if (stop) begin
            state_d  = ST_IDLE;
            gate_n_d = 1'b1;
            idx_d    = REST_IDX;
        end else if (play) begin
            state_d  = ST_FETCH;
            addr_d   = '0;
            gate_n_d = 1'b1;
            idx_d    = REST_IDX;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    gate_n_d = 1'b1;
                    idx_d    = REST_IDX;
                end
                ST_FETCH: state_d = ST_WAIT;
                ST_WAIT: begin
                    if (w_dur == '0) begin
                        state_d = (LOOP != 0) ? ST_FETCH : ST_IDLE;
                        addr_d  = (LOOP != 0) ? '0 : addr_q;
                    end else begin
                        fcw_d     = w_fcw;
                        oct_d     = oct_fix(rom_data[OCT_LSB +: OCT_W]);
                        gate_n_d  = (w_fcw == 16'd0);
                        idx_d     = (w_fcw == 16'd0) ? REST_IDX : w_idx;
                        tmr_load  = 1'b1;
                        tmr_ticks = w_dur;
                        state_d   = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (tmr_done) begin
                        state_d   = ST_GAP;
                        gate_n_d  = 1'b1;
                        idx_d     = REST_IDX;
                        tmr_load  = 1'b1;
                        tmr_ticks = DUR_W'(GAP_TICKS);
                    end
                end
                ST_GAP: begin
                    // The last ROM slot ends the song like an end marker.
                    if (tmr_done) begin
                        if (addr_q == {ADDR_W{1'b1}}) begin
                            state_d = (LOOP != 0) ? ST_FETCH : ST_IDLE;
                            addr_d  = '0;
                            if (LOOP == 0) addr_d = addr_q;
                        end else begin
                            state_d = ST_FETCH;
                            addr_d  = addr_q + ADDR_W'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            fcw_q    <= '0;
            oct_q    <= 3'd1;
            gate_n_q <= 1'b1;
            idx_q    <= REST_IDX;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            fcw_q    <= fcw_d;
            oct_q    <= oct_d;
            gate_n_q <= gate_n_d;
            idx_q    <= idx_d;
        end
    end

    assign rom_addr  = addr_q;
    assign fcw       = fcw_q;
    assign octave    = oct_q;
    assign gate_n    = gate_n_q;
    assign busy      = (state_q != ST_IDLE);
    assign note_idx  = idx_q;
    assign state_dbg = state_q;

endmodule
